// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha3_pkg
// Purpose  : Shared Keccak types for the loader and the round stages.
//            lane_t is one 64-bit lane; state_t is the 5x5 lane array
//            indexed [x][y], the layout every round stage consumes.
// Revision : 1.0  initial release
// ============================================================================
package sha3_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;

  typedef logic [63:0] lane_t;
  typedef lane_t [4:0][4:0] state_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_st_t;

endpackage : sha3_pkg
`default_nettype wire

// File: rtl/sha3_xy_counter.sv
`default_nettype none
// ============================================================================
// Module   : sha3_xy_counter
// Purpose  : x/y lane position inside a 5x5 Keccak state.
// Ports    : clk, reset (async, active high)
//            advance  - step x, wrapping to 0 with y+1
//            resync   - jump to (1,0) (lane 0 was just written)
//            clear    - return to (0,0)
//            x, y     - current position
//            last     - position is (LAST_XY, LAST_XY)
//            origin   - position is (0,0)
// Priority : clear > resync > advance.
// Revision : 1.0  initial release
// ============================================================================
module sha3_xy_counter #(
  parameter logic [2:0] LAST_XY = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       resync,
  input  logic       clear,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       last,
  output logic       origin
);

  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;

  always_comb begin : p_next_pos
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = 3'd0;
      y_d = 3'd0;
    end else if (resync) begin
      x_d = 3'd1;
      y_d = 3'd0;
    end else if (advance) begin
      if (x_q == LAST_XY) begin
        x_d = 3'd0;
        y_d = (y_q == LAST_XY) ? 3'd0 : y_q + 3'd1;
      end else begin
        x_d = x_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_pos_reg
    if (reset) begin
      x_q <= 3'd0;
      y_q <= 3'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign last   = (x_q == LAST_XY) && (y_q == LAST_XY);
  assign origin = (x_q == 3'd0) && (y_q == 3'd0);

endmodule : sha3_xy_counter
`default_nettype wire

// File: rtl/sha3_lane_loader.sv
`default_nettype none
// ============================================================================
// Module   : sha3_lane_loader
// Purpose  : Serial-to-parallel front end of the Keccak pipeline. Collects
//            one lane per cycle into the [x][y] state and offers the full
//            state downstream with a push/stop handshake.
// Ports    : clk, reset (async, active high)
//            pushin/firstin/lanein - lane input, firstin marks lane 0
//            stopout               - high while the state is held (FULL)
//            pushout/sha3_m        - complete state, lane k at [k%5][k/5]
//            stopin                - downstream stall
//            errout                - sticky framing error (late firstin)
// Revision : 1.0  initial release
// ============================================================================
module sha3_lane_loader
  import sha3_pkg::*;
#(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pushin,
  input  logic              firstin,
  input  logic [LANE_W-1:0] lanein,
  output logic              stopout,
  output logic              pushout,
  input  logic              stopin,
  output state_t            sha3_m,
  output logic              errout
);

  // Edge index of the square state (4 for a 5x5 state).
  localparam logic [2:0] C_LAST_XY = 3'(NUM_LANES / 5 - 1);

  loader_st_t state_q, state_d;
  logic       pushout_q, pushout_d;
  logic       stopout_q, stopout_d;
  logic       errout_q, errout_d;
  state_t     sha3_m_q, sha3_m_d;

  logic [2:0] pos_x, pos_y;
  logic       pos_last, pos_origin;
  logic       fill_push, do_resync, do_lane;
  logic [2:0] wr_x, wr_y;

  // Lanes are only taken in FILL; a lane offered in FULL is dropped.
  assign fill_push = (state_q == FILL) && pushin;
  assign do_resync = fill_push && firstin;
  assign do_lane   = fill_push && !firstin;

  sha3_xy_counter #(
    .LAST_XY (C_LAST_XY)
  ) u_xy (
    .clk     (clk),
    .reset   (reset),
    .advance (do_lane && !pos_last),
    .resync  (do_resync),
    .clear   (do_lane && pos_last),
    .x       (pos_x),
    .y       (pos_y),
    .last    (pos_last),
    .origin  (pos_origin)
  );

  // A resync always lands on (0,0), whatever the counter says.
  assign wr_x = do_resync ? 3'd0 : pos_x;
  assign wr_y = do_resync ? 3'd0 : pos_y;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin : p_state_reg
    if (reset) begin
      state_q   <= FILL;
      pushout_q <= 1'b0;
      stopout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pushout_q <= pushout_d;
      stopout_q <= stopout_d;
    end
  end

  // A firstin arriving on the last position is a resync, not completion.
  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      FILL:    if (do_lane && pos_last) state_d = FULL;
      FULL:    if (!stopin) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop.
  always_comb begin : p_outputs
    pushout_d = (state_d == FULL);
    stopout_d = (state_d == FULL);
  end

  // ----------------------------------------------------- lane storage
  always_comb begin : p_lane_write
    sha3_m_d = sha3_m_q;
    for (int xi = 0; xi < 5; xi++) begin
      for (int yi = 0; yi < 5; yi++) begin
        if ((do_lane || do_resync) && (wr_x == 3'(xi)) && (wr_y == 3'(yi))) begin
          sha3_m_d[xi][yi] = lanein;
        end
      end
    end
  end

  always_comb begin : p_err
    errout_d = errout_q | (do_resync && !pos_origin);
  end

  always_ff @(posedge clk or posedge reset) begin : p_data_reg
    if (reset) begin
      sha3_m_q <= '0;
      errout_q <= 1'b0;
    end else begin
      sha3_m_q <= sha3_m_d;
      errout_q <= errout_d;
    end
  end

  assign pushout = pushout_q;
  assign stopout = stopout_q;
  assign errout  = errout_q;
  assign sha3_m  = sha3_m_q;

endmodule : sha3_lane_loader
`default_nettype wire

// File: tb/tb_sha3_lane_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha3_lane_loader
// Purpose  : Directed self-checking bench for sha3_lane_loader. Expected
//            states are queued as lanes are driven and popped when the
//            loader raises pushout.
// Revision : 1.0  initial release
// ============================================================================
module tb_sha3_lane_loader;
  import sha3_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pushin;
  logic        firstin;
  logic [63:0] lanein;
  logic        stopout;
  logic        pushout;
  logic        stopin;
  state_t      sha3_m;
  logic        errout;

  int          compared   = 0;
  int          mismatched = 0;
  state_t      exp_q[$];
  state_t      exp_m;
  lane_t       chi[25];

  sha3_lane_loader #(
    .LANE_W    (64),
    .NUM_LANES (25)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pushin  (pushin),
    .firstin (firstin),
    .lanein  (lanein),
    .stopout (stopout),
    .pushout (pushout),
    .stopin  (stopin),
    .sha3_m  (sha3_m),
    .errout  (errout)
  );

  always #5 clk = ~clk;

  function automatic lane_t lane_gen(input int seed, input int k);
    return 64'h0123456789abcdef ^ (64'(seed) << 40) ^ (64'(k + 1) * 64'h9e3779b97f4a7c15);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lane(input lane_t v, input logic f);
    pushin  = 1'b1;
    firstin = f;
    lanein  = v;
    tick();
    pushin  = 1'b0;
    firstin = 1'b0;
  endtask

  task automatic compare_state(input string tag, input state_t e);
    for (int xi = 0; xi < 5; xi++)
      for (int yi = 0; yi < 5; yi++)
        chk($sformatf("%s[%0d][%0d]", tag, xi, yi), sha3_m[xi][yi], e[xi][yi]);
  endtask

  task automatic wait_pushout(input string tag, input int budget);
    int n = 0;
    while (pushout !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_pushout"}, 64'(pushout), 64'd1);
  endtask

  task automatic pop_compare(input string tag);
    chk({tag, "_queue_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      exp_m = exp_q.pop_front();
      compare_state(tag, exp_m);
    end
  endtask

  task automatic load_state(input int seed, input bit use_chi, input bit quiet);
    state_t e;
    lane_t  v;
    e = '0;
    for (int k = 0; k < 25; k++) begin
      v = use_chi ? chi[k] : lane_gen(seed, k);
      e[k % 5][k / 5] = v;
    end
    exp_q.push_back(e);
    for (int k = 0; k < 25; k++) begin
      v = use_chi ? chi[k] : lane_gen(seed, k);
      send_lane(v, k == 0);
      if (quiet && k < 24) chk($sformatf("early_pushout_%0d", k), 64'(pushout), 64'd0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    state_t e;
    lane_t  v;
    int     k;
    bit     sent;
    int     npulse;
    int     pulse_c[2];

    for (int i = 0; i < 25; i++) chi[i] = lane_gen(7, i);
    chi[0]  = 64'hfae2cf38d2ad8042;
    chi[1]  = 64'h1527be32214951d8;
    chi[5]  = 64'h7b5c0d61fc4833f9;
    chi[24] = 64'h58e84fae2bd55c81;

    reset = 1'b1; pushin = 1'b0; firstin = 1'b0; stopin = 1'b0; lanein = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Reset state
    chk("rst_pushout", 64'(pushout), 64'd0);
    chk("rst_stopout", 64'(stopout), 64'd0);
    chk("rst_errout",  64'(errout),  64'd0);
    compare_state("rst_lane", '0);

    // Full load with the chi vector, one-cycle handoff
    load_state(0, 1'b1, 1'b1);
    wait_pushout("full_load", 3);
    chk("full_stopout", 64'(stopout), 64'd1);
    pop_compare("full_lane");
    chk("chi_00", sha3_m[0][0], 64'hfae2cf38d2ad8042);
    chk("chi_10", sha3_m[1][0], 64'h1527be32214951d8);
    chk("chi_01", sha3_m[0][1], 64'h7b5c0d61fc4833f9);
    chk("chi_44", sha3_m[4][4], 64'h58e84fae2bd55c81);
    tick();
    chk("handoff_pushout", 64'(pushout), 64'd0);
    chk("handoff_stopout", 64'(stopout), 64'd0);

    // Stall for 10 cycles with a lane pushed against stopout
    stopin = 1'b1;
    load_state(2, 1'b0, 1'b0);
    wait_pushout("stall_load", 3);
    for (int c = 0; c < 10; c++) begin
      pushin = 1'b1; firstin = 1'b0; lanein = 64'hdeadbeef00000000;
      tick();
      chk($sformatf("stall_pushout_%0d", c), 64'(pushout), 64'd1);
      chk($sformatf("stall_stopout_%0d", c), 64'(stopout), 64'd1);
    end
    pop_compare("stall_lane");
    stopin = 1'b0;   // release together with a pushed lane: lane is ignored
    tick();
    pushin = 1'b0;
    chk("release_pushout", 64'(pushout), 64'd0);
    chk("release_stopout", 64'(stopout), 64'd0);
    chk("release_errout",  64'(errout),  64'd0);
    compare_state("post_stall_lane", exp_m);

    // Resync after 7 lanes, then 24 more; hold FULL with stopin
    stopin = 1'b1;
    send_lane(lane_gen(3, 0), 1'b1);
    chk("origin_kept_errout", 64'(errout), 64'd0);
    for (int i = 1; i < 7; i++) send_lane(lane_gen(3, i), 1'b0);
    chk("pre_resync_errout", 64'(errout), 64'd0);
    send_lane(64'h0123456789abcdef, 1'b1);
    chk("resync_errout", 64'(errout), 64'd1);
    chk("resync_lane00", sha3_m[0][0], 64'h0123456789abcdef);
    e = '0;
    e[0][0] = 64'h0123456789abcdef;
    for (int i = 1; i < 25; i++) e[i % 5][i / 5] = lane_gen(4, i);
    exp_q.push_back(e);
    for (int i = 1; i < 25; i++) begin
      send_lane(lane_gen(4, i), 1'b0);
      if (i < 24) chk($sformatf("resync_early_%0d", i), 64'(pushout), 64'd0);
    end
    wait_pushout("resync_load", 3);
    pop_compare("resync_lane");
    chk("errout_sticky", 64'(errout), 64'd1);

    // Asynchronous reset in the middle of a cycle while FULL
    #3 reset = 1'b1;
    #1;
    chk("async_rst_pushout", 64'(pushout), 64'd0);
    chk("async_rst_stopout", 64'(stopout), 64'd0);
    chk("async_rst_errout",  64'(errout),  64'd0);
    compare_state("async_rst_lane", '0);
    #2 reset = 1'b0;
    stopin = 1'b0;
    tick();

    // Back-to-back states honouring stopout
    e = '0;
    for (int i = 0; i < 25; i++) e[i % 5][i / 5] = lane_gen(5, i);
    exp_q.push_back(e);
    e = '0;
    for (int i = 0; i < 25; i++) e[i % 5][i / 5] = lane_gen(6, i);
    exp_q.push_back(e);
    k = 0;
    npulse = 0;
    pulse_c[0] = 0;
    pulse_c[1] = 0;
    for (int c = 0; c < 120 && npulse < 2; c++) begin
      sent = 1'b0;
      if (k < 50 && !stopout) begin
        pushin  = 1'b1;
        firstin = (k % 25 == 0);
        lanein  = (k < 25) ? lane_gen(5, k) : lane_gen(6, k - 25);
        sent    = 1'b1;
      end else begin
        pushin  = 1'b0;
        firstin = 1'b0;
      end
      tick();
      if (sent) k++;
      if (pushout === 1'b1) begin
        pulse_c[npulse] = c;
        npulse++;
        pop_compare($sformatf("b2b%0d_lane", npulse));
      end
    end
    pushin = 1'b0;
    firstin = 1'b0;
    chk("b2b_pulses", 64'(npulse), 64'd2);
    chk("b2b_spacing", 64'(pulse_c[1] - pulse_c[0]), 64'd26);
    chk("b2b_errout", 64'(errout), 64'd0);
    tick();

    // Reset after 12 lanes, then a fresh full load
    for (int i = 0; i < 12; i++) send_lane(lane_gen(8, i), i == 0);
    #3 reset = 1'b1;
    #3 reset = 1'b0;
    tick();
    load_state(9, 1'b0, 1'b1);
    wait_pushout("rst_fill_load", 1);
    pop_compare("rst_fill_lane");
    tick();
    chk("rst_fill_drop", 64'(pushout), 64'd0);

    // firstin on the last lane is a resync, not completion
    for (int i = 0; i < 24; i++) send_lane(lane_gen(10, i), i == 0);
    send_lane(lane_gen(10, 24), 1'b1);
    chk("first_at_last_pushout", 64'(pushout), 64'd0);
    chk("first_at_last_stopout", 64'(stopout), 64'd0);
    chk("first_at_last_errout",  64'(errout),  64'd1);
    chk("first_at_last_lane00", sha3_m[0][0], lane_gen(10, 24));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_sha3_lane_loader
`default_nettype wire
